// File: rtl/alu_secuenciador_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_secuenciador_if
// Description : Bus bundle between the sequencer and its peers: the
//               instruction ROM port, the combinational ALU port, and the
//               data-memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_secuenciador_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32
);
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [4:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operando_a;
  logic [DATA_W-1:0] alu_operando_b;
  logic [DATA_W-1:0] alu_resultado;
  logic              alu_C;
  logic              alu_S;
  logic              alu_O;
  logic              alu_Z;
  logic              dmem_we;
  logic [7:0]        dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;

  // Sequencer side
  modport master (
    output imem_addr, alu_opcode, alu_operando_a, alu_operando_b,
           dmem_we, dmem_addr, dmem_wdata,
    input  imem_data, alu_resultado, alu_C, alu_S, alu_O, alu_Z
  );

  // ROM / ALU / data-memory side
  modport slave (
    input  imem_addr, alu_opcode, alu_operando_a, alu_operando_b,
           dmem_we, dmem_addr, dmem_wdata,
    output imem_data, alu_resultado, alu_C, alu_S, alu_O, alu_Z
  );
endinterface
`default_nettype wire

// File: rtl/alu_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : alu_secuenciador
// Description : Three-cycle (FETCH/DECODE/EXEC) instruction sequencer that
//               drives a combinational ALU, owns an 8-entry register file and
//               a {C,S,O,Z} flag register, resolves JMP/JZ and issues STR
//               writes to data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_secuenciador #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  alu_secuenciador_if.master bus
);
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_LD  = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_JMP = 5'd4;
  localparam logic [4:0] OP_JZ  = 5'd5;
  localparam logic [4:0] OP_STR = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] regs_q [8];
  logic [3:0]        flags_q;      // {C,S,O,Z}
  logic              busy_q, done_q, error_q;
  logic [PC_W-1:0]   imem_addr_q;
  logic [4:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              dmem_we_q;
  logic [7:0]        dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;

  // Fields of the word arriving from the ROM (used in DECODE)
  logic [4:0]        dec_op;
  logic [2:0]        dec_rd, dec_rs;
  logic [7:0]        dec_imm;
  logic [DATA_W-1:0] dec_imm_sx, dec_imm_zx, dec_rd_zx;
  assign dec_op     = bus.imem_data[15:11];
  assign dec_rd     = bus.imem_data[10:8];
  assign dec_rs     = bus.imem_data[7:5];
  assign dec_imm    = bus.imem_data[7:0];
  assign dec_imm_sx = {{(DATA_W-8){dec_imm[7]}}, dec_imm};
  assign dec_imm_zx = {{(DATA_W-8){1'b0}}, dec_imm};
  assign dec_rd_zx  = {{(DATA_W-3){1'b0}}, dec_rd};

  // Fields of the latched instruction (used in EXEC)
  logic [4:0] ex_op;
  logic [2:0] ex_rd;
  logic [7:0] ex_addr;
  assign ex_op   = instr_q[15:11];
  assign ex_rd   = instr_q[10:8];
  assign ex_addr = instr_q[7:0];

  logic [PC_W-1:0] pc_d;
  logic            ex_known;
  logic            ex_halt;

  // Next pc, halt detection and opcode validity for the instruction in EXEC
  always_comb begin
    pc_d     = pc_q + PC_W'(1);
    ex_known = 1'b0;
    ex_halt  = 1'b0;
    case (ex_op)
      OP_NOP, OP_LD, OP_ADD, OP_MUL, OP_STR: ex_known = 1'b1;
      OP_JMP: begin
        ex_known = 1'b1;
        pc_d     = ex_addr[PC_W-1:0];
        ex_halt  = (ex_addr == 8'(pc_q));
      end
      OP_JZ: begin
        ex_known = 1'b1;
        // Branch on the committed Z flag, never on the live ALU output
        if (flags_q[0]) pc_d = ex_addr[PC_W-1:0];
      end
      default: ex_known = 1'b0;
    endcase
  end

  // Sequencer FSM, register file, flags and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      flags_q      <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      imem_addr_q  <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      dmem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            imem_addr_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          state_q      <= S_EXEC;
          instr_q      <= bus.imem_data;
          alu_opcode_q <= dec_op;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          case (dec_op)
            OP_LD: begin
              alu_a_q <= dec_rd_zx;
              alu_b_q <= dec_imm_sx;
            end
            OP_ADD, OP_MUL: begin
              alu_a_q <= regs_q[dec_rd];
              alu_b_q <= regs_q[dec_rs];
            end
            OP_STR: begin
              alu_a_q      <= regs_q[dec_rd];
              alu_b_q      <= dec_imm_zx;
              dmem_we_q    <= 1'b1;
              dmem_addr_q  <= dec_imm;
              dmem_wdata_q <= regs_q[dec_rd];
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (ex_op == OP_LD || ex_op == OP_ADD || ex_op == OP_MUL) begin
            regs_q[ex_rd] <= bus.alu_resultado;
            flags_q       <= {bus.alu_C, bus.alu_S, bus.alu_O, bus.alu_Z};
          end
          if (!ex_known) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else if (ex_halt) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_FETCH;
            pc_q        <= pc_d;
            imem_addr_q <= pc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign bus.imem_addr      = imem_addr_q;
  assign bus.alu_opcode     = alu_opcode_q;
  assign bus.alu_operando_a = alu_a_q;
  assign bus.alu_operando_b = alu_b_q;
  // A reset arriving during a store's EXEC cycle must suppress the write
  // at that same edge, so the strobe is qualified by rst_n.
  assign bus.dmem_we        = dmem_we_q & rst_n;
  assign bus.dmem_addr      = dmem_addr_q;
  assign bus.dmem_wdata     = dmem_wdata_q;
endmodule
`default_nettype wire
